// File: rtl/shift_tx_ctrl.sv
// rtl/shift_tx_ctrl.sv - byte-to-serial frame sequencer driving an external 8-bit load/shift register
module shift_tx_ctrl #(
  parameter int unsigned GAP  = 1,     // idle cycles between frames, 0..15
  parameter logic        FILL = 1'b0   // constant shifted into the register
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       abort,
  output logic [7:0] sr_d,
  output logic       sr_ld,
  output logic       sr_si,
  input  logic       sr_so,
  output logic       tx_bit,
  output logic       tx_frame,
  output logic       done,
  output logic [7:0] frame_cnt,
  output logic       busy
);

  // Last gap count value; unused when GAP is zero because the GAP state is skipped.
  localparam logic [3:0] GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);
  localparam logic       GAP_ZERO = (GAP == 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t     state;
  logic [2:0] bc;
  logic [3:0] gc;
  logic [7:0] buf_data;
  logic       buf_full;
  logic [7:0] cnt;

  logic       accept;
  logic       last_bit;
  logic       gap_end;
  logic       load;

  assign accept = in_valid && in_ready;

  // Decode the frame boundary conditions and the register load strobe.
  always_comb begin
    last_bit = (state == S_SHIFT) && (bc == 3'd7);
    gap_end  = (state == S_GAP) && (gc == GAP_LAST);
    load     = 1'b0;
    unique case (state)
      S_IDLE:  load = buf_full;
      S_SHIFT: load = last_bit && GAP_ZERO && buf_full;
      S_GAP:   load = gap_end && buf_full;
      default: load = 1'b0;
    endcase
  end

  // Frame sequencer: idle, eight shift cycles, then the programmed idle gap.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state <= S_IDLE;
      bc    <= 3'd0;
      gc    <= 4'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (buf_full) begin
            state <= S_SHIFT;
            bc    <= 3'd0;
          end
        end
        S_SHIFT: begin
          if (bc == 3'd7) begin
            bc <= 3'd0;
            gc <= 4'd0;
            if (!GAP_ZERO) begin
              state <= S_GAP;
            end else if (buf_full) begin
              state <= S_SHIFT;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            bc <= bc + 3'd1;
          end
        end
        S_GAP: begin
          if (gc == GAP_LAST) begin
            gc    <= 4'd0;
            bc    <= 3'd0;
            state <= buf_full ? S_SHIFT : S_IDLE;
          end else begin
            gc <= gc + 4'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          bc    <= 3'd0;
          gc    <= 4'd0;
        end
      endcase
    end
  end

  // One-entry byte buffer; accept needs it empty and load needs it full, so they never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full <= 1'b0;
      buf_data <= 8'h00;
    end else if (abort) begin
      buf_full <= 1'b0;
    end else if (accept) begin
      buf_full <= 1'b1;
      buf_data <= in_data;
    end else if (load) begin
      buf_full <= 1'b0;
    end
  end

  // Completed-frame counter; a last bit that coincides with abort still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (last_bit) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Outputs are forced to their idle values while reset is held.
  assign in_ready  = !buf_full && !rst;
  assign sr_d      = buf_data;
  assign sr_si     = FILL;
  assign sr_ld     = load && !rst;
  assign tx_frame  = (state == S_SHIFT) && !rst;
  assign tx_bit    = sr_so && tx_frame;
  assign done      = last_bit && !rst;
  assign busy      = !rst && ((state != S_IDLE) || buf_full);
  assign frame_cnt = rst ? 8'd0 : cnt;

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// tb/tb_shift_tx_ctrl.sv - self-checking bench for shift_tx_ctrl with GAP=1, GAP=0 and GAP=3 instances
module tb_shift_tx_ctrl;

  localparam int N = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       in_data   [N];
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic [N-1:0]     abort;
  logic [7:0]       sr_d      [N];
  logic [N-1:0]     sr_ld;
  logic [N-1:0]     sr_si;
  logic [N-1:0]     sr_so;
  logic [N-1:0]     tx_bit;
  logic [N-1:0]     tx_frame;
  logic [N-1:0]     done;
  logic [7:0]       frame_cnt [N];
  logic [N-1:0]     busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instance 0: GAP=1 FILL=0, instance 1: GAP=0 FILL=0, instance 2: GAP=3 FILL=1.
  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [7:0] sh = 8'h00;

    shift_tx_ctrl #(
      .GAP  (g == 0 ? 1 : (g == 1 ? 0 : 3)),
      .FILL (g == 2)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .abort     (abort[g]),
      .sr_d      (sr_d[g]),
      .sr_ld     (sr_ld[g]),
      .sr_si     (sr_si[g]),
      .sr_so     (sr_so[g]),
      .tx_bit    (tx_bit[g]),
      .tx_frame  (tx_frame[g]),
      .done      (done[g]),
      .frame_cnt (frame_cnt[g]),
      .busy      (busy[g])
    );

    // Behavioural 8-bit load/shift register, MSB out.
    always @(posedge clk) sh <= sr_ld[g] ? sr_d[g] : {sh[6:0], sr_si[g]};
    assign sr_so[g] = sh[7];
  end

  function automatic int gap_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  function automatic int fill_of(input int i);
    return (i == 2) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int i, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t actual=%0d expected=%0d", name, i, $time, act, exp);
    end
  endtask

  // Transaction-level model: one buffered byte, frame start times and the earliest next start.
  bit         m_full  [N];
  bit         m_has   [N];
  int         m_start [N];
  logic [7:0] m_buf   [N];
  logic [7:0] m_byte  [N];
  int         m_cnt   [N];
  int         n = 0;

  logic [7:0] rx_q [$];
  logic [7:0] rx_sh = 8'h00;
  int         rx_nb = 0;

  initial begin
    bit act, e_frame, e_bit, e_done, e_ld, e_busy, e_rdy, acc;
    for (int i = 0; i < N; i++) begin
      m_full[i] = 0; m_has[i] = 0; m_start[i] = 0; m_buf[i] = 0; m_byte[i] = 0; m_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        act     = m_has[i] && (n >= m_start[i]) && (n <= m_start[i] + 7);
        e_frame = !rst && act;
        e_bit   = 0;
        if (e_frame) e_bit = m_byte[i][7 - (n - m_start[i])];
        e_done  = e_frame && (n == m_start[i] + 7);
        e_ld    = !rst && m_full[i] && (!m_has[i] || (n + 1 >= m_start[i] + 8 + gap_of(i)));
        e_busy  = !rst && (m_full[i] || (m_has[i] && (n <= m_start[i] + 7 + gap_of(i))));
        e_rdy   = !rst && !m_full[i];
        acc     = in_valid[i] && e_rdy;

        chk("tx_frame", i, tx_frame[i], e_frame);
        chk("tx_bit", i, tx_bit[i], e_bit);
        chk("done", i, done[i], e_done);
        chk("sr_ld", i, sr_ld[i], e_ld);
        chk("busy", i, busy[i], e_busy);
        chk("in_ready", i, in_ready[i], e_rdy);
        chk("frame_cnt", i, frame_cnt[i], rst ? 0 : m_cnt[i]);
        chk("sr_si", i, sr_si[i], fill_of(i));
        if (m_full[i] && !rst) chk("sr_d", i, sr_d[i], m_buf[i]);

        if (rst) begin
          m_full[i] = 0; m_has[i] = 0; m_cnt[i] = 0;
        end else if (abort[i]) begin
          if (e_done) m_cnt[i] = (m_cnt[i] + 1) % 256;
          m_full[i] = 0; m_has[i] = 0;
        end else begin
          if (e_done) m_cnt[i] = (m_cnt[i] + 1) % 256;
          if (e_ld) begin
            m_has[i] = 1; m_start[i] = n + 1; m_byte[i] = m_buf[i]; m_full[i] = 0;
          end
          if (acc) begin
            m_buf[i] = in_data[i]; m_full[i] = 1;
          end
        end
      end
      if (tx_frame[0]) begin
        rx_sh = {rx_sh[6:0], tx_bit[0]};
        rx_nb++;
        if (rx_nb == 8) begin
          rx_q.push_back(rx_sh);
          rx_nb = 0;
        end
      end
      n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [7:0] b);
    bit ok;
    int t;
    ok = 0;
    t = 0;
    in_data[i] = b;
    in_valid[i] = 1'b1;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = in_ready[i];
      tick();
      t++;
    end
    in_valid[i] = 1'b0;
    chk("send_accepted", i, ok, 1);
  endtask

  task automatic wait_frame(input int i, output bit ok);
    ok = 0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      ok = tx_frame[i];
    end
    chk("frame_started", i, ok, 1);
  endtask

  task automatic wait_idle(input int i);
    bit ok;
    ok = 0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      ok = !busy[i];
    end
    chk("went_idle", i, ok, 1);
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic exp_a5 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] bp_bytes [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    int seen;

    rst = 1'b1;
    in_valid = '0;
    abort = '0;
    for (int i = 0; i < N; i++) in_data[i] = 8'h00;

    // Reset state.
    tick();
    @(negedge clk);
    chk("rst_in_ready", 0, in_ready[0], 0);
    chk("rst_busy", 0, busy[0], 0);
    chk("rst_frame_cnt", 0, frame_cnt[0], 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 0, in_ready[0], 1);

    // GAP=1, single byte 0xA5.
    tick();
    send(0, 8'hA5);
    @(negedge clk);
    chk("a5_sr_ld", 0, sr_ld[0], 1);
    chk("a5_pre_frame", 0, tx_frame[0], 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("a5_frame", 0, tx_frame[0], 1);
      chk("a5_bit", 0, tx_bit[0], exp_a5[k]);
      chk("a5_done", 0, done[0], (k == 7));
    end
    @(negedge clk);
    chk("a5_cnt", 0, frame_cnt[0], 1);
    chk("a5_post_frame", 0, tx_frame[0], 0);
    wait_idle(0);

    // GAP=0, 0xFF then 0x00 back-to-back.
    tick();
    fork
      begin
        send(1, 8'hFF);
        send(1, 8'h00);
      end
      begin
        bit ok;
        wait_frame(1, ok);
        if (ok) begin
          for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            chk("g0_frame", 1, tx_frame[1], 1);
            chk("g0_bit", 1, tx_bit[1], (k < 8));
            if (k == 7) begin
              chk("g0_done", 1, done[1], 1);
              chk("g0_reload", 1, sr_ld[1], 1);
            end
          end
          @(negedge clk);
          chk("g0_end", 1, tx_frame[1], 0);
        end
      end
    join
    wait_idle(1);

    // GAP=3, 0x81 then 0x3C with in_valid held, FILL=1 behind the gap.
    tick();
    fork
      begin
        send(2, 8'h81);
        send(2, 8'h3C);
      end
      begin
        bit ok;
        int gap;
        logic [7:0] b1, b2;
        b1 = 8'h00;
        b2 = 8'h00;
        gap = 0;
        wait_frame(2, ok);
        if (ok) begin
          b1 = {b1[6:0], tx_bit[2]};
          for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            b1 = {b1[6:0], tx_bit[2]};
          end
          for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (tx_frame[2]) break;
            gap++;
            chk("g3_ready_low", 2, in_ready[2], 0);
            chk("g3_gap_bit", 2, tx_bit[2], 0);
          end
          chk("g3_gap_len", 2, gap, 3);
          chk("g3_ready_after_load", 2, in_ready[2], 1);
          b2 = {b2[6:0], tx_bit[2]};
          for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            b2 = {b2[6:0], tx_bit[2]};
          end
          chk("g3_byte1", 2, b1, 8'h81);
          chk("g3_byte2", 2, b2, 8'h3C);
        end
      end
    join
    wait_idle(2);

    // Backpressure: 0x01..0x05 offered with in_valid held.
    rx_q.delete();
    rx_nb = 0;
    tick();
    for (int k = 0; k < 5; k++) send(0, bp_bytes[k]);
    wait_idle(0);
    chk("bp_count", 0, rx_q.size(), 5);
    for (int k = 0; k < 5 && k < rx_q.size(); k++) chk("bp_byte", 0, rx_q[k], bp_bytes[k]);
    chk("bp_frame_cnt", 0, frame_cnt[0], 6);

    // Abort at bit 2 with a second byte buffered.
    tick();
    fork
      begin
        send(0, 8'h5A);
        send(0, 8'hC3);
      end
      begin
        bit ok;
        wait_frame(0, ok);
        tick();
        tick();
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        @(negedge clk);
        chk("ab_frame", 0, tx_frame[0], 0);
        chk("ab_busy", 0, busy[0], 0);
        chk("ab_cnt_held", 0, frame_cnt[0], 6);
        chk("ab_done", 0, done[0], 0);
        chk("ab_ready", 0, in_ready[0], 1);
      end
    join
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      seen += int'(tx_frame[0]);
    end
    chk("ab_never_sent", 0, seen, 0);

    // Reset at bit 4 with a second byte buffered.
    tick();
    fork
      begin
        send(0, 8'h77);
        send(0, 8'h99);
      end
      begin
        bit ok;
        wait_frame(0, ok);
        repeat (4) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rs_ready_low", 0, in_ready[0], 0);
        chk("rs_done_low", 0, done[0], 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rs_frame", 0, tx_frame[0], 0);
        chk("rs_busy", 0, busy[0], 0);
        chk("rs_cnt", 0, frame_cnt[0], 0);
        chk("rs_done", 0, done[0], 0);
        chk("rs_ready", 0, in_ready[0], 1);
      end
    join
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      seen += int'(tx_frame[0]);
    end
    chk("rs_never_sent", 0, seen, 0);

    // 256 single-byte frames: counter reaches 255 then wraps to 0.
    tick();
    for (int k = 0; k < 255; k++) send(0, 8'(k));
    wait_idle(0);
    chk("wrap_255", 0, frame_cnt[0], 255);
    tick();
    send(0, 8'hFF);
    wait_idle(0);
    chk("wrap_0", 0, frame_cnt[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
